uart_tx: RTL

UART transmitter for the CPU's `tx` pin: the sending end of the 8N1 serial link the core's receiver already consumes on `rx`. It accepts bytes from the core over a valid/ready write port into a small FIFO. It serializes each byte as one start bit, eight data bits LSB-first, and one stop bit. The default bit period gives 9600 baud from the 100 MHz system clock.

---
 rtl/uart_tx.sv | 139 +++++++++++++
 1 files changed

// File: rtl/uart_tx.sv
// 8N1 UART transmitter: byte FIFO on a valid/ready write port, serialised
// LSB-first with one start and one stop bit; tx is registered and idles high.
module uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 10417,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          wr_en,
  input  logic [7:0]                    wr_data,
  output logic                          wr_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          busy,
  output logic                          tx
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [AW:0]   DEPTH_C  = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] bit_cnt_q, bit_cnt_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;
  logic          busy_q, busy_d;

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [AW:0]   count_q, count_d;
  logic          push, pop;

  assign wr_ready   = (count_q != DEPTH_C);
  assign push       = wr_en && wr_ready;
  assign fifo_count = count_q;
  assign busy       = busy_q;
  assign tx         = tx_q;

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  // tx is a register fed from the current state, so the line lags the FSM by
  // exactly one cycle and every bit keeps its full CLKS_PER_BIT length.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q + 1'b1;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    pop       = 1'b0;
    tx_d      = 1'b1;
    unique case (state_q)
      IDLE: begin
        bit_cnt_d = '0;
        if (count_q != '0) begin
          pop     = 1'b1;
          shift_d = mem_q[rptr_q];
          state_d = START;
        end
      end
      START: begin
        tx_d = 1'b0;
        if (bit_cnt_q == BIT_LAST) begin
          bit_cnt_d = '0;
          bit_idx_d = '0;
          state_d   = DATA;
        end
      end
      DATA: begin
        tx_d = shift_q[0];
        if (bit_cnt_q == BIT_LAST) begin
          bit_cnt_d = '0;
          shift_d   = {1'b0, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 1'b1;
          if (bit_idx_q == 3'd7) state_d = STOP;
        end
      end
      STOP: begin
        tx_d = 1'b1;
        if (bit_cnt_q == BIT_LAST) begin
          bit_cnt_d = '0;
          if (count_q != '0) begin
            pop     = 1'b1;
            shift_d = mem_q[rptr_q];
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // Registered busy must cover the pop cycle and the lagging stop bit.
    busy_d = (state_d != IDLE) || (state_q != IDLE) || (count_d != '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
    end
  end

endmodule
